stage_wr: RTL and testbench
===========================

// Module: stage_wr
// PURPOSE
//   Write-back stage of the 5-stage pipelined CPU. Holds the MEM/WR pipeline register and
//   selects the result (ALU or load data). Drives WR_RegWE/WR_Rw/WR_RegDin into the
//   decode-stage register file, which is the consumer end of those signals.
//   Adds stall/flush control, $0 write suppression, a retired-instruction counter and an
//   optional forwarding hold register.
// PARAMETERS
//   DATA_W      32  datapath width
//   CNT_W       32  width of retire counter
//   ZERO_GUARD  1   1: never assert write enable for Rw==0
// PORTS
//   Clk             in   1       rising-edge clock
//   Reset           in   1       synchronous, active-high reset
//   MEMin_valid     in   1       MEM stage presents a real instruction (0 = bubble)
//   MEMin_RegWr     in   1       instruction writes a register
//   MEMin_MemtoReg  in   1       1: write load data; 0: write ALU result
//   MEMin_Rw        in   5       destination register
//   MEMin_ALUout    in   DATA_W  ALU result
//   MEMin_Dout      in   DATA_W  data-memory read data
//   Stall           in   1       hold the WR register
//   Flush           in   1       replace the WR entry with a bubble
//   WR_RegWE        out  1       register-file write enable
//   WR_Rw           out  5       register-file write address
//   WR_RegDin       out  DATA_W  register-file write data
//   WR_valid        out  1       WR register holds a real instruction
//   WR_RetireCnt    out  CNT_W   number of instructions retired
// BEHAVIOUR
//   - Reset: all fields are cleared at the same edge.
//     valid=0, fresh=0, Rw=0, data=0, WR_RetireCnt=0. All outputs read 0 in the following cycle.
//   - Edge priority: Reset > Flush > Stall > load.
//     Flush: valid=0, fresh=0, other fields don't-care (drive 0).
//     Stall: every field holds and fresh is cleared.
//     Load: capture MEMin_*; fresh=MEMin_valid.
//   - Flush and Stall both high: Flush wins and the entry becomes a bubble.
//   - Latency: 1 cycle from MEMin_* to the WR_* outputs.
//   - Result select: WR_RegDin = MemtoReg ? Dout : ALUout. The mux is taken from registered
//     fields, so the output is combinational from flops only.
//   - WR_RegWE = valid & fresh & RegWr & (ZERO_GUARD ? Rw!=0 : 1).
//     An entry therefore writes exactly once, even when it is stalled for N cycles.
//   - WR_Rw and WR_RegDin present the held entry even when WR_RegWE=0.
//   - Retire counter: increments by 1 on every load edge with MEMin_valid=1.
//     It does not count on bubbles, Flush, Stall or Reset.
//     It wraps from 2^CNT_W-1 to 0 silently.
//   - Decode stage timing: its register file writes on the Clk edge that ends the WR_RegWE
//     cycle. A decode-stage read of the same register in that cycle sees the old value;
//     the hazard unit must forward or stall for it (see CONFIGURATION).
// CONFIGURATION
//   WR_BYPASS_EN defined: extra outputs Byp_valid(1), Byp_Rw(5), Byp_Data(DATA_W).
//   - On every edge where WR_RegWE=1, the hold register captures Rw/RegDin and sets Byp_valid=1.
//   - On any other edge Byp_valid clears. The value is therefore visible for exactly one
//     cycle after commit, so decode can forward it.
//   - Reset clears Byp_valid, Byp_Rw and Byp_Data to 0. Flush does not clear the hold register.
//   WR_BYPASS_EN undefined: Byp_* ports and the hold register do not exist.
//   All other behaviour is identical in both builds.
// TESTING
//   1) Reset 2 cycles, then release.
//      -> all outputs 0; WR_RetireCnt=0.
//   2) Load {valid=1,RegWr=1,MemtoReg=0,Rw=8,ALUout=0x1234,Dout=0xDEAD}.
//      -> next cycle: WR_RegWE=1, WR_Rw=8, WR_RegDin=0x1234, RetireCnt=1.
//   3) Load {Rw=9,MemtoReg=1,Dout=0xCAFEF00D}, then Stall=1 for 3 cycles.
//      -> WR_RegWE=1 for 1 cycle only; WR_RegDin=0xCAFEF00D is held for 4 cycles;
//         RetireCnt increments once.
//   4) Load {Rw=0,RegWr=1,ALUout=5} with ZERO_GUARD=1.
//      -> WR_RegWE=0, WR_valid=1, RetireCnt increments.
//   5) Flush=1 and Stall=1 on the same edge while a valid entry is held.
//      -> WR_valid=0, WR_RegWE=0, RetireCnt unchanged.
//   6) Build with WR_BYPASS_EN; commit Rw=3, data 0x77.
//      -> next cycle Byp_valid=1, Byp_Rw=3, Byp_Data=0x77; the cycle after, Byp_valid=0.
//      Also: set CNT_W=4 and retire 17 instructions -> RetireCnt=1.

Source files
------------

// File: rtl/stage_wr.sv
// stage_wr -- write-back stage of the 5-stage pipelined CPU.
//
// Holds the MEM/WR pipeline register and selects the value written back
// (ALU result or load data). Feeds the decode-stage register file through
// WR_RegWE / WR_Rw / WR_RegDin and counts retired instructions.
//
// Optional feature macro: WR_BYPASS_EN
//   When defined, a one-cycle hold register republishes each committed
//   write on Byp_valid / Byp_Rw / Byp_Data for the decode-stage forwarding path.
//
// Ports:
//   Clk, Reset       clock, synchronous active-high reset
//   MEMin_*          MEM-stage outputs captured into the WR register
//   Stall            hold the WR register (the entry may not write twice)
//   Flush            replace the WR entry with a bubble (wins over Stall)
//   WR_RegWE/Rw/RegDin  register-file write port
//   WR_valid         WR register holds a real instruction
//   WR_RetireCnt     retired-instruction counter, wraps silently
//   Byp_*            forwarding hold register (WR_BYPASS_EN only)
module stage_wr #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 32,
    parameter bit          ZERO_GUARD = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MEMin_valid,
    input  logic              MEMin_RegWr,
    input  logic              MEMin_MemtoReg,
    input  logic [4:0]        MEMin_Rw,
    input  logic [DATA_W-1:0] MEMin_ALUout,
    input  logic [DATA_W-1:0] MEMin_Dout,
    input  logic              Stall,
    input  logic              Flush,
    output logic              WR_RegWE,
    output logic [4:0]        WR_Rw,
    output logic [DATA_W-1:0] WR_RegDin,
    output logic              WR_valid,
`ifdef WR_BYPASS_EN
    output logic              Byp_valid,
    output logic [4:0]        Byp_Rw,
    output logic [DATA_W-1:0] Byp_Data,
`endif
    output logic [CNT_W-1:0]  WR_RetireCnt
);

    logic              r_valid;
    logic              r_fresh;
    logic              r_regwr;
    logic              r_memtoreg;
    logic [4:0]        r_rw;
    logic [DATA_W-1:0] r_aluout;
    logic [DATA_W-1:0] r_dout;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_rw_ok;

    // MEM/WR pipeline register: Reset > Flush > Stall > load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid    <= 1'b0;
            r_fresh    <= 1'b0;
            r_regwr    <= 1'b0;
            r_memtoreg <= 1'b0;
            r_rw       <= '0;
            r_aluout   <= '0;
            r_dout     <= '0;
        end else if (Flush) begin
            r_valid    <= 1'b0;
            r_fresh    <= 1'b0;
            r_regwr    <= 1'b0;
            r_memtoreg <= 1'b0;
            r_rw       <= '0;
            r_aluout   <= '0;
            r_dout     <= '0;
        end else if (Stall) begin
            // Clearing fresh makes a stalled entry write exactly once.
            r_fresh    <= 1'b0;
        end else begin
            r_valid    <= MEMin_valid;
            r_fresh    <= MEMin_valid;
            r_regwr    <= MEMin_RegWr;
            r_memtoreg <= MEMin_MemtoReg;
            r_rw       <= MEMin_Rw;
            r_aluout   <= MEMin_ALUout;
            r_dout     <= MEMin_Dout;
        end
    end

    // Counts only real instructions accepted on a load edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (!Flush && !Stall && MEMin_valid) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rw_ok   = ZERO_GUARD ? (r_rw != 5'd0) : 1'b1;
        WR_RegWE  = r_valid & r_fresh & r_regwr & w_rw_ok;
        WR_Rw     = r_rw;
        WR_RegDin = r_memtoreg ? r_dout : r_aluout;
        WR_valid  = r_valid;
        WR_RetireCnt = r_cnt;
    end

`ifdef WR_BYPASS_EN
    logic              r_byp_valid;
    logic [4:0]        r_byp_rw;
    logic [DATA_W-1:0] r_byp_data;

    // Republishes the committed write for the cycle after commit, since the
    // register file only updates on the edge that ends the write cycle.
    // Flush deliberately does not touch this register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_byp_valid <= 1'b0;
            r_byp_rw    <= '0;
            r_byp_data  <= '0;
        end else if (WR_RegWE) begin
            r_byp_valid <= 1'b1;
            r_byp_rw    <= WR_Rw;
            r_byp_data  <= WR_RegDin;
        end else begin
            r_byp_valid <= 1'b0;
        end
    end

    always_comb begin
        Byp_valid = r_byp_valid;
        Byp_Rw    = r_byp_rw;
        Byp_Data  = r_byp_data;
    end
`endif

endmodule

// File: tb/tb_stage_wr.sv
// tb_stage_wr -- directed-vector bench for stage_wr.
// The DUT is built with CNT_W=4 so counter wrap is reachable; define
// WR_BYPASS_EN in both files to exercise the forwarding hold register.
module tb_stage_wr;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              MEMin_valid;
    logic              MEMin_RegWr;
    logic              MEMin_MemtoReg;
    logic [4:0]        MEMin_Rw;
    logic [DATA_W-1:0] MEMin_ALUout;
    logic [DATA_W-1:0] MEMin_Dout;
    logic              Stall;
    logic              Flush;
    logic              WR_RegWE;
    logic [4:0]        WR_Rw;
    logic [DATA_W-1:0] WR_RegDin;
    logic              WR_valid;
    logic [CNT_W-1:0]  WR_RetireCnt;
`ifdef WR_BYPASS_EN
    logic              Byp_valid;
    logic [4:0]        Byp_Rw;
    logic [DATA_W-1:0] Byp_Data;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    stage_wr #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .ZERO_GUARD (1'b1)
    ) u_dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .MEMin_valid    (MEMin_valid),
        .MEMin_RegWr    (MEMin_RegWr),
        .MEMin_MemtoReg (MEMin_MemtoReg),
        .MEMin_Rw       (MEMin_Rw),
        .MEMin_ALUout   (MEMin_ALUout),
        .MEMin_Dout     (MEMin_Dout),
        .Stall          (Stall),
        .Flush          (Flush),
        .WR_RegWE       (WR_RegWE),
        .WR_Rw          (WR_Rw),
        .WR_RegDin      (WR_RegDin),
        .WR_valid       (WR_valid),
`ifdef WR_BYPASS_EN
        .Byp_valid      (Byp_valid),
        .Byp_Rw         (Byp_Rw),
        .Byp_Data       (Byp_Data),
`endif
        .WR_RetireCnt   (WR_RetireCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic m2r, input logic [4:0] rw,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] dout);
        MEMin_valid    = v;
        MEMin_RegWr    = wr;
        MEMin_MemtoReg = m2r;
        MEMin_Rw       = rw;
        MEMin_ALUout   = alu;
        MEMin_Dout     = dout;
    endtask

    initial begin
        Reset = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // 1) reset for two cycles
        tick();
        tick();
        chk("rst_we",    64'(WR_RegWE),     64'd0);
        chk("rst_rw",    64'(WR_Rw),        64'd0);
        chk("rst_din",   64'(WR_RegDin),    64'd0);
        chk("rst_valid", 64'(WR_valid),     64'd0);
        chk("rst_cnt",   64'(WR_RetireCnt), 64'd0);
`ifdef WR_BYPASS_EN
        chk("rst_byp_v", 64'(Byp_valid), 64'd0);
        chk("rst_byp_d", 64'(Byp_Data),  64'd0);
`endif
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
        tick();
        chk("idle_valid", 64'(WR_valid),     64'd0);
        chk("idle_cnt",   64'(WR_RetireCnt), 64'd0);

        // 2) ALU result write
        drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h1234, 32'hDEAD);
        tick();
        chk("alu_we",  64'(WR_RegWE),     64'd1);
        chk("alu_rw",  64'(WR_Rw),        64'd8);
        chk("alu_din", 64'(WR_RegDin),    64'h1234);
        chk("alu_cnt", 64'(WR_RetireCnt), 64'd1);

        // 3) load-data write, then stalled for 3 cycles
        drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h5555, 32'hCAFE_F00D);
        tick();
        chk("ld_we",  64'(WR_RegWE),     64'd1);
        chk("ld_rw",  64'(WR_Rw),        64'd9);
        chk("ld_din", 64'(WR_RegDin),    64'hCAFE_F00D);
        chk("ld_cnt", 64'(WR_RetireCnt), 64'd2);
        Stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd20, 32'hAAAA, 32'hBBBB);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_we",    64'(WR_RegWE),     64'd0);
            chk("stl_rw",    64'(WR_Rw),        64'd9);
            chk("stl_din",   64'(WR_RegDin),    64'hCAFE_F00D);
            chk("stl_valid", 64'(WR_valid),     64'd1);
            chk("stl_cnt",   64'(WR_RetireCnt), 64'd2);
        end
        Stall = 1'b0;

        // 4) write to $0 is suppressed but still retires
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd5, 32'd0);
        tick();
        chk("z_we",    64'(WR_RegWE),     64'd0);
        chk("z_valid", 64'(WR_valid),     64'd1);
        chk("z_din",   64'(WR_RegDin),    64'd5);
        chk("z_cnt",   64'(WR_RetireCnt), 64'd3);

        // 5) Flush and Stall together: bubble, no count
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h44, 32'd0);
        tick();
        chk("pre_fl_we", 64'(WR_RegWE), 64'd1);
        Flush = 1'b1;
        Stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 32'd0);
        tick();
        chk("fl_valid", 64'(WR_valid),     64'd0);
        chk("fl_we",    64'(WR_RegWE),     64'd0);
        chk("fl_rw",    64'(WR_Rw),        64'd0);
        chk("fl_cnt",   64'(WR_RetireCnt), 64'd4);
        Flush = 1'b0;
        Stall = 1'b0;

        // bubble with RegWr set, then a valid non-writing instruction
        drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h77, 32'd0);
        tick();
        chk("bub_we",  64'(WR_RegWE),     64'd0);
        chk("bub_cnt", 64'(WR_RetireCnt), 64'd4);
        drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h78, 32'd0);
        tick();
        chk("nw_we",  64'(WR_RegWE),     64'd0);
        chk("nw_rw",  64'(WR_Rw),        64'd7);
        chk("nw_cnt", 64'(WR_RetireCnt), 64'd5);

`ifdef WR_BYPASS_EN
        // 6) forwarding hold register
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h77, 32'd0);
        tick();
        chk("byp_commit_we", 64'(WR_RegWE), 64'd1);
        chk("byp_pre_v",     64'(Byp_valid), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
        tick();
        chk("byp_v",  64'(Byp_valid), 64'd1);
        chk("byp_rw", 64'(Byp_Rw),    64'd3);
        chk("byp_d",  64'(Byp_Data),  64'h77);
        tick();
        chk("byp_v_clr", 64'(Byp_valid), 64'd0);
`endif

        // counter wrap with CNT_W=4: 17 retirements from reset -> 1
        Reset = 1'b1;
        tick();
        chk("wrap_rst_cnt", 64'(WR_RetireCnt), 64'd0);
        Reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd1, 32'd0, 32'd0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 15) chk("wrap_cnt15", 64'(WR_RetireCnt), 64'd15);
            if (i == 16) chk("wrap_cnt16", 64'(WR_RetireCnt), 64'd0);
        end
        chk("wrap_cnt17", 64'(WR_RetireCnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
